qx1_fetch_unit: RTL and testbench

Instruction fetch front end for the QX1 core. It owns the program counter and drives `pc` into the combinational-read instruction memory, one 16-bit instruction per cycle. Each returned `instruction` is captured with its address into a small prefetch FIFO, and the FIFO presents instructions to decode through a valid/ready handshake. The decode/execute stage can redirect fetch to a new PC, which flushes every prefetched entry.

---
 rtl/qx1_fetch_unit.sv | 76 +++++++
 tb/tb_qx1_fetch_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/qx1_fetch_unit.sv
// qx1_fetch_unit: instruction fetch front end for the QX1 core.
//   Owns the program counter, reads one 16-bit instruction per cycle from a
//   combinational-read instruction memory and queues {pc, instruction} in a
//   small prefetch FIFO that feeds decode over a valid/ready handshake.
//   A redirect reloads the PC and discards every prefetched entry.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   pc                  byte address to instruction memory (always even)
//   instruction         memory read data for pc (same cycle)
//   redirect_valid/_pc  branch/jump redirect; bit 0 of target ignored
//   instr_valid/instr/instr_pc/instr_ready  decode handshake (FIFO head)
module qx1_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  input  logic [15:0] instruction,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } entry_t;

  entry_t [DEPTH-1:0] fifo_q;
  logic   [PW-1:0]    rd_ptr, wr_ptr;
  logic   [CW-1:0]    count;
  logic   [15:0]      pc_q;
  logic               pop, push;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push        = !redirect_valid && ((count < CW'(DEPTH)) || pop);

  assign pc       = pc_q;
  assign instr    = fifo_q[rd_ptr].ins;
  assign instr_pc = fifo_q[rd_ptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC & 16'hFFFE;
      fifo_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // A same-cycle pop is already owned by decode; everything else drops.
      pc_q   <= redirect_pc & 16'hFFFE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: pc_q, ins: instruction};
        wr_ptr         <= wr_ptr + PW'(1);
        pc_q           <= pc_q + 16'd2;  // wraps modulo 2^16
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_qx1_fetch_unit.sv
module tb_qx1_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // memory[n] = 16'h1000 + n, n = word index
  assign instruction = 16'h1000 + {1'b0, pc[15:1]};

  qx1_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        ev;
    logic        cd;    // check instr/instr_pc
    logic [15:0] eipc;
    logic [15:0] eins;
    logic [15:0] epc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic rdy, logic rv, logic [15:0] rpc,
                              logic ev, logic cd, logic [15:0] eipc,
                              logic [15:0] eins, logic [15:0] epc);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.cd = cd; v.eipc = eipc; v.eins = eins; v.epc = epc;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] got, logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_outs(int idx, logic ev, logic cd, logic [15:0] eipc,
                            logic [15:0] eins, logic [15:0] epc);
    chk("instr_valid", idx, {15'd0, instr_valid}, {15'd0, ev});
    chk("pc", idx, pc, epc);
    if (cd) begin
      chk("instr_pc", idx, instr_pc, eipc);
      chk("instr", idx, instr, eins);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    //            rst rdy rv rpc       ev cd ipc       ins       pc
    // reset and streaming
    tv.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000)); // 0
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000)); // 1
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0002)); // 2
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0002, 16'h1001, 16'h0004)); // 3
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0004, 16'h1002, 16'h0006)); // 4
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0006, 16'h1003, 16'h0008)); // 5
    // backpressure: 5 cycles of ready low after reset
    tv.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000)); // 6
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000)); // 7
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0002)); // 8
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0004)); // 9
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0004)); // 10
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0004)); // 11
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0004)); // 12
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0002, 16'h1001, 16'h0006)); // 13
    // full FIFO, redirect to 0x0041 while head (4,1002) is consumed
    tv.push_back(mk(1, 1, 1, 16'h0041, 1, 1, 16'h0004, 16'h1002, 16'h0008)); // 14
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0040)); // 15
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0040, 16'h1020, 16'h0042)); // 16
    // redirect to 0xFFFC, check wrap
    tv.push_back(mk(1, 1, 1, 16'hFFFC, 1, 1, 16'h0042, 16'h1021, 16'h0044)); // 17
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFC)); // 18
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'hFFFC, 16'h8FFE, 16'hFFFE)); // 19
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'hFFFE, 16'h8FFF, 16'h0000)); // 20
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h1000, 16'h0002)); // 21
    // fill, then redirect while stalled
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h1001, 16'h0004)); // 22
    tv.push_back(mk(1, 0, 1, 16'h0100, 1, 1, 16'h0002, 16'h1001, 16'h0006)); // 23
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0100)); // 24
    // back-to-back redirects, last wins
    tv.push_back(mk(1, 1, 1, 16'h0200, 1, 1, 16'h0100, 16'h1080, 16'h0102)); // 25
    tv.push_back(mk(1, 1, 1, 16'h0303, 0, 0, 16'h0000, 16'h0000, 16'h0200)); // 26
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0302)); // 27
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 16'h0302, 16'h1181, 16'h0304)); // 28

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_n          = tv[i].rst_n;
      instr_ready    = tv[i].rdy;
      redirect_valid = tv[i].rv;
      redirect_pc    = tv[i].rpc;
      #1;
      check_outs(i, tv[i].ev, tv[i].cd, tv[i].eipc, tv[i].eins, tv[i].epc);
    end

    // async reset mid-stream with two entries queued
    @(negedge clk);
    instr_ready = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check_outs(100, 1'b1, 1'b1, 16'h0304, 16'h1182, 16'h0308);
    rst_n = 1'b0;
    #1;
    check_outs(101, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1; instr_ready = 1'b1;
    #1;
    check_outs(102, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    #1;
    check_outs(103, 1'b1, 1'b1, 16'h0000, 16'h1000, 16'h0002);
    @(negedge clk);
    #1;
    check_outs(104, 1'b1, 1'b1, 16'h0002, 16'h1001, 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
